input_conditioner: RTL

- Front-end stage directly upstream of the manual-mode controller. Conditions the 5 raw push-buttons and 8 raw slide switches from the board before the controller samples them.
- For every input it synchronises to clk, debounces, and exports a stable level. For buttons it also exports a press pulse with a fixed length and a single winner.
- The controller's button input is driven from press_pulse and its switches input from sw_stable. This keeps held or bouncing buttons from triggering repeated move/get/put/throw actions.

---
 rtl/input_conditioner_if.sv | 25 ++
 rtl/input_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_conditioner_if : raw board inputs in, conditioned levels/pulses out |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface input_conditioner_if;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic [4:0] btn_stable;
  logic [7:0] sw_stable;
  logic [4:0] press_pulse;
  logic       busy;
  logic [7:0] drop_count;

  modport master (
    output btn_raw, sw_raw,
    input  btn_stable, sw_stable, press_pulse, busy, drop_count
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_stable, sw_stable, press_pulse, busy, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_conditioner : sync + debounce of buttons/switches, single-winner    |
// | fixed-length press pulses with optional lockout.  Revision 1.0            |
// +--------------------------------------------------------------------------+
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_LEN       = 1,
  parameter int LOCKOUT_CYCLES  = 0
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input_conditioner_if.slave   bus
);

  localparam int N_IN  = 13;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int TP_W  = $clog2(PULSE_LEN + 1);
  localparam int TL_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TMR_W = (TP_W > TL_W) ? ((TP_W > 1) ? TP_W : 1) : ((TL_W > 1) ? TL_W : 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  // ---------------- two-flop synchroniser ----------------
  logic [N_IN-1:0] sync1_q, sync1_d;
  logic [N_IN-1:0] sync2_q, sync2_d;
  logic [N_IN-1:0] w_stable;

  always_comb begin
    sync1_d = {bus.sw_raw, bus.btn_raw};
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------- per-bit debounce ----------------
  for (genvar i = 0; i < N_IN; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q[i] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q[i];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign w_stable[i] = stable_q;
  end

  assign bus.btn_stable = w_stable[4:0];
  assign bus.sw_stable  = w_stable[12:5];

  // ---------------- press detection and pulse FSM ----------------
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < 5; k++) c = c + {2'b00, v[k]};
    return c;
  endfunction

  logic [4:0]       btn_prev_q, btn_prev_d;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [4:0]       sel_q, sel_d;
  logic [7:0]       drop_q, drop_d;

  logic [4:0] w_rise;
  logic [4:0] w_lowest;
  logic [2:0] w_n_drop;
  logic [8:0] w_drop_sum;

  always_comb begin
    btn_prev_d = w_stable[4:0];
    w_rise     = w_stable[4:0] & ~btn_prev_q;
    // Isolate the lowest set bit: that button wins a simultaneous press.
    w_lowest   = w_rise & (~w_rise + 5'd1);

    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (w_rise != 5'd0) begin
          state_d = ST_PULSE;
          sel_d   = w_lowest;
          timer_d = '0;
        end
      end
      ST_PULSE: begin
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          sel_d   = '0;
          state_d = (LOCKOUT_CYCLES > 0) ? ST_LOCK : ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOCK: begin
        if (timer_q == LOCK_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        sel_d   = '0;
      end
    endcase

    if (state_q == ST_IDLE && w_rise != 5'd0) w_n_drop = popcount5(w_rise) - 3'd1;
    else                                      w_n_drop = popcount5(w_rise);

    w_drop_sum = {1'b0, drop_q} + {6'b0, w_n_drop};
    drop_d     = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= '0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      sel_q      <= '0;
      drop_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      sel_q      <= sel_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.press_pulse = (state_q == ST_PULSE) ? sel_q : 5'd0;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.drop_count  = drop_q;

endmodule
`default_nettype wire
